// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-port bundle for mem_access_ctrl.
// slave = the controller, master = CPU datapath plus memory model.
`timescale 1ns/1ps
interface mem_access_ctrl_if #(
  parameter int MEM_ADDR_BITS = 10
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [31:0]              req_addr;
  logic [31:0]              req_wdata;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [31:0]              resp_rdata;
  logic                     resp_err;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [31:0]              mem_data_in;
  logic [3:0]               mem_sel;
  logic                     mem_str;
  logic                     mem_ld;
  logic [31:0]              mem_data_out;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_data_in, mem_sel, mem_str, mem_ld
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_data_in, mem_sel, mem_str, mem_ld
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller in front of a byte-enabled word memory.
// Define MISALIGN_EXC_EN to report misaligned accesses instead of truncating the address.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | one cycle driving the memory port from the latched request
// RESP   | holding the response until resp_ready
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                   state, state_nx;
  logic                     r_we;
  logic                     r_uns;
  logic [1:0]               r_size;
  logic [MEM_ADDR_BITS+1:0] r_addr;
  logic [31:0]              r_wdata;
  logic [31:0]              rdata_q;
  logic                     err_q;

  logic                     is_half;
  logic                     is_word;
  logic                     blocked;
  logic [1:0]               lane;
  logic [3:0]               sel_raw;
  logic [31:0]              wdata_rep;
  logic [31:0]              shifted;
  logic [31:0]              load_val;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:MEM_ADDR_BITS+2];

  assign is_half = (r_size == 2'b01);
  assign is_word = r_size[1];  // reserved size 11 behaves as a word

`ifdef MISALIGN_EXC_EN
  assign blocked = (is_half & r_addr[0]) | (is_word & (|r_addr[1:0]));
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    lane      = r_addr[1:0];
    sel_raw   = 4'b0001 << r_addr[1:0];
    wdata_rep = {4{r_wdata[7:0]}};
    if (is_word) begin
      lane      = 2'b00;
      sel_raw   = 4'b1111;
      wdata_rep = r_wdata;
    end else if (is_half) begin
      lane      = {r_addr[1], 1'b0};
      sel_raw   = r_addr[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{r_wdata[15:0]}};
    end
  end

  assign shifted = bus.mem_data_out >> {lane, 3'b000};

  always_comb begin
    load_val = bus.mem_data_out;
    if (!is_word) begin
      if (is_half)
        load_val = r_uns ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      else
        load_val = r_uns ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end
  end

  always_comb begin
    state_nx        = state;
    bus.mem_addr    = '0;
    bus.mem_data_in = '0;
    bus.mem_sel     = '0;
    bus.mem_str     = 1'b0;
    bus.mem_ld      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) state_nx = ACCESS;
      end
      ACCESS: begin
        bus.mem_addr    = r_addr[MEM_ADDR_BITS+1:2];
        bus.mem_data_in = wdata_rep;
        if (!blocked) begin
          bus.mem_sel = sel_raw;
          bus.mem_str = r_we;
          bus.mem_ld  = ~r_we;
        end
        state_nx = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (state == IDLE && bus.req_valid) begin
      r_we    <= bus.req_we;
      r_uns   <= bus.req_unsigned;
      r_size  <= bus.req_size;
      r_addr  <= bus.req_addr[MEM_ADDR_BITS+1:0];
      r_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      rdata_q <= (blocked || r_we) ? 32'h0 : load_val;
      err_q   <= blocked;
    end
  end

  // req_ready is gated by rst_n so it reads 0 for the whole reset window
  assign bus.req_ready  = rst_n & (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table plus hand-written
// backpressure and reset sequences against a byte-lane memory model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mem_clr;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.MEM_ADDR_BITS(AW)) bus ();
  mem_access_ctrl #(.MEM_ADDR_BITS(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] lane_mask;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{bus.mem_sel[i]}};
  end

  assign bus.mem_data_out = mem[bus.mem_addr] & lane_mask;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'h0;
    end else if (bus.mem_str) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_sel[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_data_in[8*i +: 8];
    end
  end

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_sel;
    logic [31:0]   e_din;
    logic [31:0]   e_rdata;
    logic          e_err;
  } vec_t;

  vec_t v [18];

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [AW-1:0] ea, input logic [3:0] es,
                              input logic [31:0] ed, input logic [31:0] er, input logic ee);
    vec_t t;
    t.we = we; t.size = sz; t.uns = uns; t.addr = a; t.wdata = wd;
    t.e_addr = ea; t.e_sel = es; t.e_din = ed; t.e_rdata = er; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t t);
    bus.req_we       = t.we;
    bus.req_size     = t.size;
    bus.req_unsigned = t.uns;
    bus.req_addr     = t.addr;
    bus.req_wdata    = t.wdata;
    bus.req_valid    = 1'b1;
  endtask

  // Returns with the DUT in ACCESS, #1 after the accepting edge
  task automatic accept(input string tag, output logic ok);
    int n = 0;
    while (!bus.req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bus.req_ready;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s accept: req_ready stuck low, want 1", tag);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic do_txn(input string tag, input vec_t t);
    logic ok;
    drive_req(t);
    accept(tag, ok);
    if (ok) begin
      chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(t.e_addr));
      chk({tag, " mem_sel"}, 32'(bus.mem_sel), 32'(t.e_sel));
      chk({tag, " mem_data_in"}, bus.mem_data_in, t.e_din);
      chk({tag, " mem_str"}, 32'(bus.mem_str), 32'(t.we && t.e_sel != 4'b0));
      chk({tag, " mem_ld"}, 32'(bus.mem_ld), 32'(!t.we && t.e_sel != 4'b0));
      chk({tag, " resp_valid in access"}, 32'(bus.resp_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({tag, " resp_rdata"}, bus.resp_rdata, t.e_rdata);
      chk({tag, " resp_err"}, 32'(bus.resp_err), 32'(t.e_err));
      chk({tag, " mem_str in resp"}, 32'(bus.mem_str), 32'd0);
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      chk({tag, " req_ready after resp"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    vec_t t;

    v[0]  = mk(1'b1, 2'b10, 1'b0, 32'h008, 32'hDEADBEEF, 10'd2, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    v[1]  = mk(1'b1, 2'b10, 1'b0, 32'h008, 32'h80FF7F01, 10'd2, 4'b1111, 32'h80FF7F01, 32'h0, 1'b0);
    v[2]  = mk(1'b0, 2'b00, 1'b0, 32'h00B, 32'h0, 10'd2, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0);
    v[3]  = mk(1'b0, 2'b00, 1'b1, 32'h00B, 32'h0, 10'd2, 4'b1000, 32'h0, 32'h00000080, 1'b0);
    v[4]  = mk(1'b0, 2'b00, 1'b0, 32'h00A, 32'h0, 10'd2, 4'b0100, 32'h0, 32'hFFFFFFFF, 1'b0);
    v[5]  = mk(1'b0, 2'b00, 1'b0, 32'h008, 32'h0, 10'd2, 4'b0001, 32'h0, 32'h00000001, 1'b0);
    v[6]  = mk(1'b0, 2'b01, 1'b0, 32'h008, 32'h0, 10'd2, 4'b0011, 32'h0, 32'h00007F01, 1'b0);
    v[7]  = mk(1'b0, 2'b01, 1'b0, 32'h00A, 32'h0, 10'd2, 4'b1100, 32'h0, 32'hFFFF80FF, 1'b0);
    v[8]  = mk(1'b0, 2'b01, 1'b1, 32'h00A, 32'h0, 10'd2, 4'b1100, 32'h0, 32'h000080FF, 1'b0);
    v[9]  = mk(1'b1, 2'b01, 1'b0, 32'h006, 32'hABCD1234, 10'd1, 4'b1100, 32'h12341234, 32'h0, 1'b0);
    v[10] = mk(1'b0, 2'b01, 1'b1, 32'h006, 32'h0, 10'd1, 4'b1100, 32'h0, 32'h00001234, 1'b0);
    v[11] = mk(1'b1, 2'b00, 1'b0, 32'h005, 32'h000000A5, 10'd1, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0);
    v[12] = mk(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 10'd1, 4'b1111, 32'h0, 32'h1234A500, 1'b0);
`ifdef MISALIGN_EXC_EN
    v[13] = mk(1'b0, 2'b10, 1'b0, 32'h005, 32'h0, 10'd1, 4'b0000, 32'h0, 32'h0, 1'b1);
    v[14] = mk(1'b0, 2'b01, 1'b0, 32'h007, 32'h0, 10'd1, 4'b0000, 32'h0, 32'h0, 1'b1);
`else
    v[13] = mk(1'b0, 2'b10, 1'b0, 32'h005, 32'h0, 10'd1, 4'b1111, 32'h0, 32'h1234A500, 1'b0);
    v[14] = mk(1'b0, 2'b01, 1'b0, 32'h007, 32'h0, 10'd1, 4'b1100, 32'h0, 32'h00001234, 1'b0);
`endif
    v[15] = mk(1'b0, 2'b11, 1'b0, 32'h008, 32'h0, 10'd2, 4'b1111, 32'h0, 32'h80FF7F01, 1'b0);
    v[16] = mk(1'b1, 2'b10, 1'b0, 32'h0000100C, 32'h0BADF00D, 10'd3, 4'b1111, 32'h0BADF00D, 32'h0, 1'b0);
    v[17] = mk(1'b0, 2'b10, 1'b0, 32'h00C, 32'h0, 10'd3, 4'b1111, 32'h0, 32'h0BADF00D, 1'b0);

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    mem_clr = 1'b1;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst mem_sel", 32'(bus.mem_sel), 32'd0);
    chk("rst mem_str", 32'(bus.mem_str), 32'd0);
    chk("rst mem_ld", 32'(bus.mem_ld), 32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post-rst req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 18; i++) do_txn($sformatf("v%0d", i), v[i]);

    // Backpressure: response held, concurrent request ignored
    t = mk(1'b0, 2'b10, 1'b0, 32'h008, 32'h0, 10'd2, 4'b1111, 32'h0, 32'h80FF7F01, 1'b0);
    drive_req(t);
    accept("bp", ok);
    @(posedge clk); #1;
    drive_req(mk(1'b1, 2'b10, 1'b0, 32'h008, 32'h0, 10'd2, 4'b1111, 32'h0, 32'h0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d resp_valid", k), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("bp%0d resp_rdata", k), bus.resp_rdata, 32'h80FF7F01);
      chk($sformatf("bp%0d req_ready", k), 32'(bus.req_ready), 32'd0);
      chk($sformatf("bp%0d mem_str", k), 32'(bus.mem_str), 32'd0);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("bp req_ready after", 32'(bus.req_ready), 32'd1);
    do_txn("bp readback", t);

    // Reset during the ACCESS cycle of a store must suppress the write
    drive_req(mk(1'b1, 2'b10, 1'b0, 32'h00C, 32'hFFFFFFFF, 10'd3, 4'b1111, 32'hFFFFFFFF, 32'h0, 1'b0));
    accept("rst-access", ok);
    chk("rst-access mem_str before", 32'(bus.mem_str), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst-access mem_str", 32'(bus.mem_str), 32'd0);
    chk("rst-access mem_sel", 32'(bus.mem_sel), 32'd0);
    chk("rst-access req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst-access idle", 32'(bus.req_ready), 32'd1);
    do_txn("rst-access readback", v[17]);

    // Reset while a response is pending discards it
    drive_req(v[17]);
    accept("rst-resp", ok);
    @(posedge clk); #1;
    chk("rst-resp pending", 32'(bus.resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst-resp resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst-resp resp_rdata", bus.resp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst-resp idle", 32'(bus.req_ready), 32'd1);
    do_txn("rst-resp next", v[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store access controller sitting between the CPU datapath and the byte-enabled word memory. Accepts one byte/halfword/word load or store per valid/ready handshake and drives the memory port: word address, 4-bit byte-lane select, replicated write data, store strobe and read-enable. Returns the sign- or zero-extended load result over a valid/ready response channel. Misaligned accesses are checked and reported when the check is compiled in.

## Interface
- MEM_ADDR_BITS, 10, memory word-address width; byte address bits [MEM_ADDR_BITS+1:2] select the word, higher bits ignored
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access (0 when check compiled out)
- mem_addr  out  MEM_ADDR_BITS  word address to memory
- mem_data_in  out  32  lane-replicated write data
- mem_sel  out  4  byte-lane enables, bit i = bits [8i+7:8i]
- mem_str  out  1  store strobe, committed at the clk edge
- mem_ld  out  1  read-enable
- mem_data_out  in  32  combinational, sel-masked read data from memory

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid: latch we/size/unsigned/addr/wdata, go to ACCESS.
- ACCESS (exactly one cycle): memory outputs are driven from the latched request.
  - mem_addr = addr[MEM_ADDR_BITS+1:2].
  - mem_sel: byte 0001<<addr[1:0]; half addr[1] ? 1100 : 0011; word 1111.
  - mem_data_in: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
  - Store: mem_str=1, mem_ld=0.
  - Load: mem_ld=1, mem_str=0. At the ACCESS-exit edge, resp_rdata captures the selected lane of mem_data_out, shifted down and extended per req_unsigned. Word loads are unchanged.
  - Next state RESP.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready. On resp_ready, go to IDLE. req_valid is ignored here.
- Outside ACCESS: mem_sel=0, mem_str=0, mem_ld=0, mem_data_in=0, mem_addr=0.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.

## Timing
- Reset values: req_ready=0 while rst_n=0, then 1 in IDLE. All other outputs 0.
- Reset is asynchronous. Asserting rst_n mid-ACCESS drops mem_str immediately, so no write commits. Asserting it in RESP discards the response.
- Request accepted at edge E0. ACCESS spans E0→E1. resp_valid is high from E1.
- If resp_ready=1 at E2, IDLE resumes after E2. Next accept is at E3 at earliest.
- Peak throughput: one transaction per 3 cycles.
- Store commits at E1. A load issued back-to-back after a store to the same word sees the new data.

## Configuration
- MISALIGN_EXC_EN defined:
  - A misaligned request is still accepted.
  - In ACCESS: mem_sel=0, mem_str=0, mem_ld=0, so memory is untouched.
  - Response: resp_err=1, resp_rdata=0.
- MISALIGN_EXC_EN undefined:
  - Offending low address bits are forced to 0: half ignores addr[0], word ignores addr[1:0].
  - resp_err is tied to 0.

## Test plan
- Store word 0xDEADBEEF at 0x008 → during ACCESS mem_addr=2, mem_sel=1111, mem_str=1, mem_data_in=0xDEADBEEF. resp_valid next cycle, resp_err=0, resp_rdata=0.
- Memory word 2 = 0x80FF7F01. Load byte signed at 0x00B → 0xFFFFFF80. Unsigned at 0x00B → 0x00000080. Signed at 0x00A → 0xFFFFFFFF.
- Store half 0x1234 at 0x006 → mem_addr=1, mem_sel=1100, mem_data_in=0x12341234. Then load half unsigned at 0x006 → 0x00001234.
- Load word at 0x005:
  - With MISALIGN_EXC_EN: resp_err=1, resp_rdata=0, mem_ld/mem_sel stay 0.
  - Without: reads word 1, resp_err=0.
- Hold resp_ready=0 for 3 cycles → resp_valid and resp_rdata stable, req_ready=0. A concurrent req_valid is not accepted.
- Pull rst_n low during ACCESS of a store → mem_str=0 immediately, target word unchanged on readback, FSM in IDLE after release.
